// File: rtl/fp_adder_rr_arb.sv
// fp_adder_rr_arb: round-robin share of one pipelined FP adder among N_REQ requesters; FPARB_PERF_CNT_EN adds grant/stall counters.
// Latency: issue 1 cycle after grant, response 1 cycle after adder finish (1 + L + 1 end to end).
// Backpressure: grant withheld while TAG_DEPTH additions are outstanding; responses cannot be stalled.

module fp_arb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module fp_adder_rr_arb #(
    parameter int DBL_WIDTH = 64,
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DBL_WIDTH-1:0]   req_a,
    input  logic [N_REQ*DBL_WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         add_valid,
    output logic [DBL_WIDTH-1:0]         add_a,
    output logic [DBL_WIDTH-1:0]         add_b,
    input  logic                         add_finish,
    input  logic [DBL_WIDTH-1:0]         add_result,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [DBL_WIDTH-1:0]         rsp_data,
    output logic                         busy,
    output logic                         err_orphan
`ifdef FPARB_PERF_CNT_EN
    ,
    output logic [N_REQ*32-1:0]          grant_cnt,
    output logic [31:0]                  stall_cnt
`endif
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] head_tag;
    logic [CNT_W-1:0] outstanding;
    logic             accept;
    logic             fifo_empty;
    logic             pop;

    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        cand      = '0;
        if (outstanding < CNT_W'(TAG_DEPTH)) begin
            // Scan from the farthest candidate back towards last_grant+1 so the nearest valid one wins.
            for (int k = N_REQ; k >= 1; k--) begin
                cand = IDX_W'((int'(last_grant) + k) % N_REQ);
                if (req_valid[cand]) begin
                    req_ready       = '0;
                    req_ready[cand] = 1'b1;
                    grant_idx       = cand;
                end
            end
        end
    end

    assign accept     = |(req_valid & req_ready);
    assign fifo_empty = (outstanding == '0);
    assign pop        = add_finish & ~fifo_empty;
    assign busy       = ~fifo_empty | add_valid;

    fp_arb_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .push_dat (grant_idx),
        .pop      (pop),
        .head_dat (head_tag),
        .count    (outstanding)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(N_REQ - 1);
            add_valid  <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
        end else begin
            add_valid <= accept;
            if (accept) begin
                last_grant <= grant_idx;
                add_a      <= req_a[int'(grant_idx)*DBL_WIDTH +: DBL_WIDTH];
                add_b      <= req_b[int'(grant_idx)*DBL_WIDTH +: DBL_WIDTH];
            end
        end
    end

    // Results arrive in issue order, so the FIFO head names the owner of each finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (pop) begin
                rsp_valid[head_tag] <= 1'b1;
                rsp_data            <= add_result;
            end
            if (add_finish && fifo_empty) err_orphan <= 1'b1;
        end
    end

`ifdef FPARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept)
                grant_cnt[int'(grant_idx)*32 +: 32] <= grant_cnt[int'(grant_idx)*32 +: 32] + 32'd1;
            if (|req_valid && !accept)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fp_adder_rr_arb.sv
// Randomized bench for fp_adder_rr_arb: a latency-L in-order adder model plus a queue-based arbitration/return scoreboard.
module tb_fp_adder_rr_arb;
    localparam int N  = 4;
    localparam int TD = 8;
    localparam int L  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*64-1:0]   req_a;
    logic [N*64-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic              add_valid;
    logic [63:0]       add_a;
    logic [63:0]       add_b;
    logic              add_finish;
    logic [63:0]       add_result;
    logic [N-1:0]      rsp_valid;
    logic [63:0]       rsp_data;
    logic              busy;
    logic              err_orphan;
`ifdef FPARB_PERF_CNT_EN
    logic [N*32-1:0]   grant_cnt;
    logic [31:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    fp_adder_rr_arb #(
        .DBL_WIDTH (64),
        .N_REQ     (N),
        .TAG_DEPTH (TD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .add_valid  (add_valid),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_finish (add_finish),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .err_orphan (err_orphan)
`ifdef FPARB_PERF_CNT_EN
        ,
        .grant_cnt  (grant_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct { int tag; logic [63:0] sum; } sb_t;
    typedef struct { logic [63:0] res; int due; } ad_t;

    sb_t         sb[$];
    ad_t         adq[$];
    logic [63:0] op_a [N];
    logic [63:0] op_b [N];
    int          m_last, m_out, cyc;
    bit          m_orphan, exp_add_vld;
    logic [63:0] exp_a, exp_b, exp_rsp_dat;
    logic [N-1:0] exp_rsp_vld;
    int          n_grants, n_stalls;
    int          grants_per [N];

    function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) + $bitstoreal(b));
    endfunction

    function automatic logic [63:0] rnd_dbl();
        logic [63:0] v;
        v = {$urandom, $urandom};
        v[62:52] = 11'(1000 + $urandom_range(0, 46));
        return v;
    endfunction

    // Nearest valid requester in circular distance after the last winner.
    function automatic int rr_pick(input logic [N-1:0] vld, input int last);
        int best, best_d;
        best = -1;
        best_d = N;
        for (int j = 0; j < N; j++) begin
            if (vld[j]) begin
                int d;
                d = (j - last - 1 + 2 * N) % N;
                if (d < best_d) begin
                    best_d = d;
                    best = j;
                end
            end
        end
        return best;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            op_a[i] = rnd_dbl();
            op_b[i] = rnd_dbl();
        end
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_out = 0;
        m_orphan = 0;
        exp_add_vld = 0;
        exp_a = '0;
        exp_b = '0;
        exp_rsp_dat = '0;
        exp_rsp_vld = '0;
        n_grants = 0;
        n_stalls = 0;
        for (int i = 0; i < N; i++) grants_per[i] = 0;
        sb.delete();
        adq.delete();
    endtask

    task automatic step(input logic [N-1:0] vld, input bit hold, input bit orphan);
        int pick;
        bit fin, popv;
        logic [N-1:0] exp_rdy;
        sb_t e;
        @(negedge clk);
        chk("add_valid", 64'(add_valid), 64'(exp_add_vld));
        chk("add_a", add_a, exp_a);
        chk("add_b", add_b, exp_b);
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_vld));
        chk("rsp_data", rsp_data, exp_rsp_dat);
        chk("busy", 64'(busy), 64'(m_out != 0 || exp_add_vld));
        chk("err_orphan", 64'(err_orphan), 64'(m_orphan));
        if (add_valid) adq.push_back('{fadd(add_a, add_b), cyc + L});
        req_valid = vld;
        for (int i = 0; i < N; i++) begin
            req_a[i*64 +: 64] = op_a[i];
            req_b[i*64 +: 64] = op_b[i];
        end
        fin = 0;
        if (!hold && adq.size() > 0 && adq[0].due <= cyc) begin
            fin = 1;
            add_result = adq[0].res;
            void'(adq.pop_front());
        end else if (orphan && m_out == 0 && adq.size() == 0) begin
            fin = 1;
            add_result = {$urandom, $urandom};
        end else begin
            add_result = {$urandom, $urandom};
        end
        add_finish = fin;
        #1;
        pick = (m_out < TD) ? rr_pick(vld, m_last) : -1;
        exp_rdy = '0;
        if (pick >= 0) exp_rdy[pick] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        popv = fin && (m_out > 0);
        exp_rsp_vld = '0;
        if (popv) begin
            e = sb.pop_front();
            exp_rsp_vld[e.tag] = 1'b1;
            exp_rsp_dat = e.sum;
        end else if (fin) begin
            m_orphan = 1;
        end
        exp_add_vld = (pick >= 0);
        if (pick >= 0) begin
            exp_a = op_a[pick];
            exp_b = op_b[pick];
            m_last = pick;
            sb.push_back('{pick, fadd(op_a[pick], op_b[pick])});
            n_grants++;
            grants_per[pick]++;
        end else if (vld != '0) begin
            n_stalls++;
        end
        m_out = m_out + ((pick >= 0) ? 1 : 0) - (popv ? 1 : 0);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_add_valid", 64'(add_valid), 64'(0));
        chk("rst_add_a", add_a, 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", rsp_data, 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err_orphan", 64'(err_orphan), 64'(0));
        req_valid = '0;
        add_finish = 1'b0;
        model_reset();
        repeat (L + 1) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (m_out == 0) break;
            step('0, 0, 0);
        end
        chk("drain_bound", 64'(m_out), 64'(0));
    endtask

    initial begin
        int n, cnt;
        rst_n = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        add_finish = 1'b0;
        add_result = '0;
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        do_reset();

        // Single request: 1.0 + 2.0 from requester 2.
        op_a[2] = 64'h3FF0000000000000;
        op_b[2] = 64'h4000000000000000;
        step(4'b0100, 0, 0);
        chk("single_grant", 64'(req_ready), 64'(4'b0100));
        step('0, 0, 0);
        chk("single_issue", 64'(add_valid), 64'(1));
        n = 1;
        while (rsp_valid == '0 && n < 20) begin
            step('0, 0, 0);
            n++;
        end
        chk("single_latency", 64'(n), 64'(L + 2));
        chk("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        chk("single_rsp_data", rsp_data, 64'h4008000000000000);
        drain();

        // All requesters valid after reset: strict rotation from requester 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step(4'hF, 0, 0);
            chk("rr_order", 64'(req_ready), 64'(1) << (i % N));
        end
        drain();

        repeat (600) begin
            rand_ops();
            step(N'($urandom), ($urandom_range(0, 3) == 0), 0);
        end
        drain();

        // Finish withheld: exactly TAG_DEPTH grants, then blocked.
        do_reset();
        cnt = 0;
        repeat (12) begin
            rand_ops();
            step(4'hF, 1, 0);
            if (req_ready != '0) cnt++;
        end
        chk("bp_grants", 64'(cnt), 64'(TD));
        repeat (20) begin
            rand_ops();
            step(4'hF, 0, 0);
        end
        drain();

        // Orphan finish while idle, sticky under further traffic.
        step('0, 0, 1);
        repeat (4) step('0, 0, 0);
        chk("orphan_sticky", 64'(err_orphan), 64'(1));
        repeat (40) begin
            rand_ops();
            step(N'($urandom), 0, 0);
        end
        drain();

        // Reset with three additions outstanding.
        repeat (3) begin
            rand_ops();
            step(4'hF, 1, 0);
        end
        chk("mid_busy", 64'(busy), 64'(1));
        do_reset();
        rand_ops();
        step(4'hF, 0, 0);
        chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));
        drain();

`ifdef FPARB_PERF_CNT_EN
        do_reset();
        repeat (100) begin
            rand_ops();
            step(4'hF, ($urandom_range(0, 3) == 0), 0);
        end
        step('0, 1, 0);
        begin
            int s;
            s = 0;
            for (int i = 0; i < N; i++) begin
                s += int'(grant_cnt[i*32 +: 32]);
                chk("grant_cnt_req", 64'(grant_cnt[i*32 +: 32]), 64'(grants_per[i]));
            end
            chk("grant_cnt_sum", 64'(s), 64'(n_grants));
            chk("stall_cnt", 64'(stall_cnt), 64'(n_stalls));
        end
        drain();
`endif

        $display("info: last-phase grants=%0d stalls=%0d req0=%0d", n_grants, n_stalls, grants_per[0]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
